cop0_write_buffer: RTL
======================

# cop0_write_buffer

Parametrised write buffer between the execute stage and the COP0 register file. It accepts explicit writes (`mtc0`) and implicit Status updates (exception entry, `eret`, `ei`, `di`) as one ordered stream and queues them in a DEPTH-entry FIFO. Entries drain to the COP0 write port through a valid/ready handshake. The block forwards pending values to readers, so the execute stage always sees the architecturally youngest Status, and it coalesces back-to-back writes to the same register.

## Interface
Parameters:
- `DEPTH`, 4: number of buffer entries; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: a write request is present.
- `in_ready` out 1: the request is accepted this cycle.
- `in_op` in `cop0_info::wop_t`: one of `WOP_MTC0`, `WOP_EXC`, `WOP_ERET`, `WOP_EI`, `WOP_DI`.
- `in_rd` in 5: register number. Used for `WOP_MTC0` only.
- `in_sel` in 3: select field. Used for `WOP_MTC0` only.
- `in_rt` in 32: source data for `WOP_MTC0`.
- `status_committed` in 32: current Status value held in the COP0 register file.
- `fwd_rd` in 5: forwarding read address, register number.
- `fwd_sel` in 3: forwarding read address, select field.
- `fwd_hit` out 1: a pending entry matches `{fwd_rd,fwd_sel}`.
- `fwd_data` out 32: data of the youngest matching entry; 0 when there is no hit.
- `status_view` out 32: youngest pending Status value, else `status_committed`.
- `out_valid` out 1: a head entry is present.
- `out_ready` in 1: the COP0 write port accepts the head entry.
- `out_rd` out 5: head entry register number.
- `out_sel` out 3: head entry select field.
- `out_data` out 32: head entry data.
- `count` out `CNT_W`: number of occupied entries.
- `full` out 1: `count==DEPTH`.
- `empty` out 1: `count==0`.

## Operation
- Entry: `{rd, sel, data}`. It is stored post-filter, so the COP0 side writes the data verbatim.
- The Status address is `rd=12`, `sel=0`.
- `WOP_MTC0`: the data is `in_rt` passed through `cop0_write_filter` for `{in_rd,in_sel}`.
- Implicit ops target the Status address. Their data is computed from the current (pre-push) `status_view`:
  - `WOP_EXC`: set EXL.
  - `WOP_ERET`: if ERL=1, clear ERL; otherwise clear EXL.
  - `WOP_EI`: set IE.
  - `WOP_DI`: clear IE.
- An `mtc0` to Status followed by an implicit op in the next cycle composes correctly, because the implicit op reads `status_view`.
- Coalescing condition: the tail (youngest) entry has the same `{rd,sel}` as the request. The tail must not be the head being popped this cycle (`count==1 && out_valid && out_ready`).
  - On coalesce the tail data is overwritten and `count` is unchanged.
- `in_ready = !full || coalesce || (out_valid && out_ready)`.
- Push and pop in the same cycle: `count` is unchanged; the pop takes the old head.
- Forwarding is combinational, with a youngest-first priority search over the occupied entries only. Stale slots are never matched.
- `status_view` is the forwarding result for the Status address, with `status_committed` as the fallback.
- Pointer wrap is modulo `DEPTH`. `full` and `empty` are derived from `count`, never from pointer equality alone.
- `in_valid` with `in_ready=0`: nothing changes. The producer holds the request.
- Reset, asynchronous: pointers are 0, `count=0`, `empty=1`, `full=0`, and `out_valid=0`.
  - Storage contents are don't-care, but `out_rd`, `out_sel` and `out_data` read 0 while `empty`.
  - A reset mid-drain discards all pending entries.

## Timing
- Push to `out_valid`: 1 cycle. An entry accepted in cycle N is at the head in N+1 if the buffer was empty.
- Push to `status_view` and `fwd_*`: visible from cycle N+1. In cycle N the outputs reflect the pre-push state.
- Pop: the head advances on the edge where `out_valid && out_ready`.
- Drain rate: 1 entry per cycle. `out_*` holds stable while `out_valid && !out_ready`.
- Throughput: 1 push per cycle while not full, or unconditionally with concurrent pop or coalesce.

## Structure
- Package `cop0_info` gains:
  - `wop_t`, a 3-bit enum.
  - `STATUS_RD=12` and `STATUS_SEL=0`.
  - The existing `IDX_STATUS_EXL`, `IDX_STATUS_ERL` and `IDX_STATUS_IE` indices are reused.
- Sub-module `cop0_status_op`: combinational, `(op, status_in) -> status_out`. It is instantiated once.
- The existing `cop0_write_filter` is instantiated once on the `mtc0` path.
- The FIFO, coalesce logic and forwarding search live in the top module.

## Test plan
- Reset with `out_ready=0`, then push `mtc0` rd=12/sel=0 with data `0x0000_0001`:
  - After the edge, `count=1`, `out_valid=1` and `status_view=0x0000_0001`.
- With `status_committed=0x0000_0000`, push `WOP_EXC`, then `WOP_ERET`, then `WOP_EI` in consecutive cycles with `out_ready=0`:
  - Coalescing gives `count=1`.
  - `status_view` steps 0x2, then 0x0, then 0x1.
  - The drained value is `0x0000_0001`.
- Fill to `DEPTH` with distinct rd values (e.g. 9, 11, 14, 16):
  - `full=1` and `in_ready=0` for a push to rd=10.
  - Assert `out_ready=1`: the push is accepted the same cycle, `count` stays 4, and pop order is 9, 11, 14, 16, 10.
- Two pending writes to rd=14, not adjacent (14, 9, 14):
  - `fwd_rd=14` returns the second value with `fwd_hit=1`.
  - After draining all entries, `fwd_hit=0` and `fwd_data=0`.
- Drive `count=1` with the head popping while pushing the same address:
  - No coalesce occurs; a new entry is allocated; `count` stays 1 with the new data.
- Assert `reset` with 3 entries pending and `out_ready` toggling:
  - Outputs go to reset values immediately, without waiting for `clk`.
  - `status_view` equals `status_committed`.

Source files
------------

// File: rtl/cop0_write_buffer_pkg.sv
// COP0 shared definitions: write-op encoding, Status address and bit indices,
// Status writable-bit mask and the write-buffer entry layout.
package cop0_info;

  typedef enum logic [2:0] {
    WOP_MTC0 = 3'd0,
    WOP_EXC  = 3'd1,
    WOP_ERET = 3'd2,
    WOP_EI   = 3'd3,
    WOP_DI   = 3'd4
  } wop_t;

  localparam logic [4:0] STATUS_RD  = 5'd12;
  localparam logic [2:0] STATUS_SEL = 3'd0;

  localparam int unsigned IDX_STATUS_IE  = 0;
  localparam int unsigned IDX_STATUS_EXL = 1;
  localparam int unsigned IDX_STATUS_ERL = 2;

  // Software-writable Status bits: CU0, BEV, IM[7:0], UM, ERL, EXL, IE.
  localparam logic [31:0] STATUS_WMASK = 32'h1040_FF17;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cop0_status_op.sv
// Computes the Status value produced by an implicit Status update.
// Ports: op = write op, status_in = current Status view,
// status_out = updated Status (unchanged for WOP_MTC0 or unknown ops).
module cop0_status_op
  import cop0_info::*;
(
  input  wop_t        op,
  input  logic [31:0] status_in,
  output logic [31:0] status_out
);

  always_comb begin
    status_out = status_in;
    unique case (op)
      WOP_EXC: status_out[IDX_STATUS_EXL] = 1'b1;
      WOP_ERET: begin
        // Error level takes precedence over exception level on return.
        if (status_in[IDX_STATUS_ERL]) status_out[IDX_STATUS_ERL] = 1'b0;
        else                           status_out[IDX_STATUS_EXL] = 1'b0;
      end
      WOP_EI:  status_out[IDX_STATUS_IE] = 1'b1;
      WOP_DI:  status_out[IDX_STATUS_IE] = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/cop0_write_filter.sv
// Masks mtc0 data to the software-writable bits of the target register.
// Ports: rd/sel = target register, data_in = raw rt value,
// data_out = value to be written verbatim into the register file.
module cop0_write_filter
  import cop0_info::*;
(
  input  logic [4:0]  rd,
  input  logic [2:0]  sel,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (rd == STATUS_RD && sel == STATUS_SEL) begin
      data_out = data_in & STATUS_WMASK;
    end
  end

endmodule

// File: rtl/cop0_write_buffer.sv
// Ordered COP0 write buffer with tail coalescing and youngest-first forwarding.
// Ports: in_* = write request (valid/ready), status_committed = register-file
// Status; fwd_rd/fwd_sel -> fwd_hit/fwd_data = pending-value lookup;
// status_view = youngest Status; out_* = head entry (valid/ready) towards the
// register file; count/full/empty = occupancy.
module cop0_write_buffer
  import cop0_info::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  wop_t             in_op,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_sel,
  input  logic [31:0]      in_rt,
  input  logic [31:0]      status_committed,
  input  logic [4:0]       fwd_rd,
  input  logic [2:0]       fwd_sel,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data,
  output logic [31:0]      status_view,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_sel,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [CNT_W-1:0] count_q;

  logic        pop, push, alloc, coalesce;
  logic        req_is_mtc0;
  logic [4:0]  req_rd;
  logic [2:0]  req_sel;
  logic [31:0] req_data, mtc0_data, implicit_data;
  logic [32:0] fwd_res, status_res;

  // Youngest-first search over occupied slots only; later (younger) hits win.
  function automatic logic [32:0] search(input logic [4:0] rd, input logic [2:0] sel);
    logic [32:0]      res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && mem_q[idx].rd == rd && mem_q[idx].sel == sel) begin
        res = {1'b1, mem_q[idx].data};
      end
    end
    return res;
  endfunction

  always_comb begin
    fwd_res    = search(fwd_rd, fwd_sel);
    status_res = search(STATUS_RD, STATUS_SEL);
  end

  assign fwd_hit     = fwd_res[32];
  assign fwd_data    = fwd_res[31:0];
  assign status_view = status_res[32] ? status_res[31:0] : status_committed;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign tail_ptr  = wr_ptr_q - PTR_W'(1);

  cop0_write_filter u_write_filter (
    .rd       (in_rd),
    .sel      (in_sel),
    .data_in  (in_rt),
    .data_out (mtc0_data)
  );

  // Implicit ops build on the youngest pending Status so back-to-back updates compose.
  cop0_status_op u_status_op (
    .op         (in_op),
    .status_in  (status_view),
    .status_out (implicit_data)
  );

  assign req_is_mtc0 = (in_op == WOP_MTC0);
  assign req_rd      = req_is_mtc0 ? in_rd  : STATUS_RD;
  assign req_sel     = req_is_mtc0 ? in_sel : STATUS_SEL;
  assign req_data    = req_is_mtc0 ? mtc0_data : implicit_data;

  // A lone entry that is leaving this cycle cannot absorb the new write.
  assign coalesce = !empty && mem_q[tail_ptr].rd == req_rd && mem_q[tail_ptr].sel == req_sel &&
                    !(count_q == CNT_W'(1) && pop);
  assign in_ready = !full || coalesce || pop;
  assign push     = in_valid && in_ready;
  assign alloc    = push && !coalesce;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (alloc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (alloc && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!alloc && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (coalesce) mem_q[tail_ptr].data <= req_data;
      else          mem_q[wr_ptr_q]      <= '{rd: req_rd, sel: req_sel, data: req_data};
    end
  end

  assign out_rd   = empty ? '0 : mem_q[rd_ptr_q].rd;
  assign out_sel  = empty ? '0 : mem_q[rd_ptr_q].sel;
  assign out_data = empty ? '0 : mem_q[rd_ptr_q].data;

endmodule
